// File: rtl/up_image_gen_if.sv
// Pixel stream bus between the test-image source and the USB TX FIFO.
// Carries one beat plus frame/row markers under a valid/ready handshake.
interface up_image_gen_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_sof;
    logic              out_eol;
    logic              out_eof;

    modport master (
        output out_data,
        output out_valid,
        output out_sof,
        output out_eol,
        output out_eof,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_sof,
        input  out_eol,
        input  out_eof,
        output out_ready
    );
endinterface

// File: rtl/up_image_gen.sv
// Parametrised test-image source: one rows x cols frame per start, selectable pattern, valid/ready output.
// Define FRAME_HEADER_EN to prepend a 3-beat header (sync, {mode,cols}, frame count) to every frame.
module up_image_gen #(
    parameter int DATA_W    = 16,
    parameter int DIM_W     = 13,
    parameter int DELAY_W   = 20,
    parameter int DEF_DELAY = 400000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DIM_W-1:0]  cfg_cols,
    input  logic [DIM_W-1:0]  cfg_rows,
    input  logic [1:0]        cfg_mode,
    up_image_gen_if.master    out_if,
    output logic              busy,
    output logic              done,
    output logic [15:0]       frame_cnt
);

`ifdef FRAME_HEADER_EN
    typedef enum logic [2:0] {S_IDLE, S_DELAY, S_HEADER, S_STREAM, S_DONE} state_t;
    localparam bit HAS_HDR = 1'b1;
`else
    typedef enum logic [2:0] {S_IDLE, S_DELAY, S_STREAM, S_DONE} state_t;
    localparam bit HAS_HDR = 1'b0;
`endif

    localparam logic [DELAY_W-1:0] DELAY_LAST = DELAY_W'(DEF_DELAY - 1);

    state_t             r_state;
    state_t             w_nextState;
    logic [DIM_W-1:0]   r_cols;
    logic [DIM_W-1:0]   r_rows;
    logic [1:0]         r_mode;
    logic [DELAY_W-1:0] r_delayCnt;
    logic [DIM_W-1:0]   r_col;
    logic [DIM_W-1:0]   r_row;
    logic [15:0]        r_frameCnt;
`ifdef FRAME_HEADER_EN
    logic [1:0]         r_hdrCnt;
`endif

    logic               w_valid;
    logic               w_xfer;
    logic               w_abortNow;
    logic               w_delayDone;
    logic               w_zeroSize;
    logic               w_lastCol;
    logic               w_lastRow;
    logic [DATA_W-1:0]  w_pixel;
    logic [DATA_W-1:0]  w_data;
    logic               w_sof;
    logic               w_eol;
    logic               w_eof;

`ifdef FRAME_HEADER_EN
    assign w_valid = (r_state == S_STREAM) || (r_state == S_HEADER);
`else
    assign w_valid = (r_state == S_STREAM);
`endif
    assign w_xfer      = w_valid && out_if.out_ready;
    assign w_abortNow  = abort && (r_state != S_IDLE);
    assign w_delayDone = (r_delayCnt == DELAY_LAST);
    assign w_zeroSize  = (r_cols == '0) || (r_rows == '0);
    assign w_lastCol   = (r_col == r_cols - DIM_W'(1));
    assign w_lastRow   = (r_row == r_rows - DIM_W'(1));

    always_comb begin
        w_pixel = '0;
        case (r_mode)
            2'd0:    w_pixel = DATA_W'(r_col);
            2'd1:    w_pixel = '1;
            2'd2:    w_pixel = {DATA_W{r_col[3] ^ r_row[3]}};
            default: w_pixel = DATA_W'(r_col) + DATA_W'(r_row) + DATA_W'(r_frameCnt);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Abort overrides every other transition, including a beat transfer in the same cycle.
    always_comb begin
        w_nextState = r_state;
        w_data      = '0;
        w_sof       = 1'b0;
        w_eol       = 1'b0;
        w_eof       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_nextState = S_DELAY;
            end
            S_DELAY: begin
`ifdef FRAME_HEADER_EN
                if (w_delayDone) w_nextState = S_HEADER;
`else
                if (w_delayDone) w_nextState = w_zeroSize ? S_DONE : S_STREAM;
`endif
            end
`ifdef FRAME_HEADER_EN
            S_HEADER: begin
                case (r_hdrCnt)
                    2'd0: begin
                        w_data = '1;
                        w_sof  = 1'b1;
                    end
                    2'd1:    w_data = DATA_W'({r_mode, r_cols});
                    default: w_data = DATA_W'(r_frameCnt);
                endcase
                if (w_xfer && (r_hdrCnt == 2'd2)) w_nextState = w_zeroSize ? S_DONE : S_STREAM;
            end
`endif
            S_STREAM: begin
                w_data = w_pixel;
                w_sof  = !HAS_HDR && (r_col == '0) && (r_row == '0);
                w_eol  = w_lastCol;
                w_eof  = w_lastCol && w_lastRow;
                if (w_xfer && w_lastCol && w_lastRow) w_nextState = S_DONE;
            end
            S_DONE: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
        if (w_abortNow) w_nextState = S_IDLE;
    end

    // Configuration is captured only on an accepted start so a running frame never changes shape.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cols     <= '0;
            r_rows     <= '0;
            r_mode     <= '0;
            r_delayCnt <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_frameCnt <= '0;
`ifdef FRAME_HEADER_EN
            r_hdrCnt   <= '0;
`endif
        end else if (w_abortNow) begin
            r_delayCnt <= '0;
            r_col      <= '0;
            r_row      <= '0;
`ifdef FRAME_HEADER_EN
            r_hdrCnt   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cols     <= cfg_cols;
                        r_rows     <= cfg_rows;
                        r_mode     <= cfg_mode;
                        r_delayCnt <= '0;
                    end
                end
                S_DELAY: begin
                    r_delayCnt <= w_delayDone ? '0 : r_delayCnt + DELAY_W'(1);
                end
`ifdef FRAME_HEADER_EN
                S_HEADER: begin
                    if (w_xfer) r_hdrCnt <= (r_hdrCnt == 2'd2) ? 2'd0 : r_hdrCnt + 2'd1;
                end
`endif
                S_STREAM: begin
                    if (w_xfer) begin
                        if (w_lastCol) begin
                            r_col <= '0;
                            r_row <= w_lastRow ? '0 : r_row + DIM_W'(1);
                        end else begin
                            r_col <= r_col + DIM_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
            if ((w_nextState == S_DONE) && (r_state != S_DONE)) r_frameCnt <= r_frameCnt + 16'd1;
        end
    end

    assign out_if.out_data  = w_data;
    assign out_if.out_valid = w_valid;
    assign out_if.out_sof   = w_sof;
    assign out_if.out_eol   = w_eol;
    assign out_if.out_eof   = w_eof;
    assign busy             = (r_state != S_IDLE);
    assign done             = (r_state == S_DONE);
    assign frame_cnt        = r_frameCnt;

endmodule

// File: tb/tb_up_image_gen.sv
// Scoreboard bench for up_image_gen: stimulus pushes expected beats, a negedge monitor pops and compares.
// Header beats are expected automatically when FRAME_HEADER_EN is defined.
module tb_up_image_gen;
    localparam int DATA_W     = 16;
    localparam int DIM_W      = 13;
    localparam int DELAY_W    = 20;
    localparam int DEF_DELAY  = 6;
    localparam int CLK_PERIOD = 10;
`ifdef FRAME_HEADER_EN
    localparam bit HAS_HDR = 1'b1;
`else
    localparam bit HAS_HDR = 1'b0;
`endif

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sof;
        logic              eol;
        logic              eof;
    } beat_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic [DIM_W-1:0] cfgCols;
    logic [DIM_W-1:0] cfgRows;
    logic [1:0]       cfgMode;
    logic             busy;
    logic             done;
    logic [15:0]      frameCnt;

    up_image_gen_if #(.DATA_W(DATA_W)) bus ();

    up_image_gen #(
        .DATA_W(DATA_W),
        .DIM_W(DIM_W),
        .DELAY_W(DELAY_W),
        .DEF_DELAY(DEF_DELAY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .cfg_cols(cfgCols),
        .cfg_rows(cfgRows),
        .cfg_mode(cfgMode),
        .out_if(bus.master),
        .busy(busy),
        .done(done),
        .frame_cnt(frameCnt)
    );

    initial clk = 1'b0;
    always #(CLK_PERIOD / 2) clk = ~clk;

    beat_t       expQ[$];
    int          checkCount = 0;
    int          passCount  = 0;
    int          xferCount  = 0;
    logic [15:0] modelFrameCnt = 16'd0;
    time         lastXferTime = 0;
    beat_t       held;
    bit          heldValid = 1'b0;
    bit          toggleReady = 1'b0;
    bit          pokeStart = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    function automatic logic [DATA_W-1:0] expPixel(input int col, input int row, input int mode,
                                                   input logic [15:0] fc);
        logic [31:0] c = 32'(col);
        logic [31:0] r = 32'(row);
        case (mode)
            0:       return DATA_W'(c);
            1:       return '1;
            2:       return {DATA_W{c[3] ^ r[3]}};
            default: return DATA_W'(c + r + 32'(fc));
        endcase
    endfunction

    task automatic pushBeat(input logic [DATA_W-1:0] d, input bit s, input bit e, input bit f,
                            inout int n, input int maxBeats);
        beat_t b;
        b.data = d;
        b.sof  = s;
        b.eol  = e;
        b.eof  = f;
        if (n < maxBeats) expQ.push_back(b);
        n++;
    endtask

    task automatic pushFrame(input int cols, input int rows, input int mode, input int maxBeats);
        int n = 0;
        if (HAS_HDR) begin
            pushBeat('1, 1'b1, 1'b0, 1'b0, n, maxBeats);
            pushBeat(DATA_W'({2'(mode), DIM_W'(cols)}), 1'b0, 1'b0, 1'b0, n, maxBeats);
            pushBeat(DATA_W'(modelFrameCnt), 1'b0, 1'b0, 1'b0, n, maxBeats);
        end
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                pushBeat(expPixel(c, r, mode, modelFrameCnt), !HAS_HDR && (r == 0) && (c == 0),
                         c == cols - 1, (c == cols - 1) && (r == rows - 1), n, maxBeats);
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the start pulse has been sampled.
    task automatic applyStimulus(input int cols, input int rows, input int mode, input int maxBeats);
        pushFrame(cols, rows, mode, maxBeats);
        cfgCols = DIM_W'(cols);
        cfgRows = DIM_W'(rows);
        cfgMode = 2'(mode);
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
    endtask

    task automatic waitDone(input string name, input bit hasBeats, output int cycles);
        bit seen = 1'b0;
        cycles = 0;
        while (!seen && cycles < DEF_DELAY + 400) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                if (toggleReady) bus.out_ready = ~bus.out_ready;
                if (pokeStart) begin
                    start   = 1'b1;
                    cfgRows = DIM_W'(1);
                    cfgCols = DIM_W'(1);
                end
                cycles++;
            end
        end
        checkOutput({name, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            modelFrameCnt++;
            checkOutput({name, "_frame_cnt"}, 32'(frameCnt), 32'(modelFrameCnt));
            checkOutput({name, "_valid_in_done"}, 32'(bus.out_valid), 32'd0);
            checkOutput({name, "_all_beats"}, 32'(expQ.size()), 32'd0);
            if (hasBeats) checkOutput({name, "_done_after_eof"}, 32'($time - lastXferTime), 32'(CLK_PERIOD));
            @(posedge clk);
            #1;
            start = 1'b0;
            bus.out_ready = 1'b1;
            @(negedge clk);
            checkOutput({name, "_done_one_cycle"}, 32'(done), 32'd0);
            checkOutput({name, "_busy_cleared"}, 32'(busy), 32'd0);
            @(posedge clk);
            #1;
        end
        toggleReady = 1'b0;
        pokeStart   = 1'b0;
        start       = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    // Monitor: checks every transferred beat against the scoreboard and every stalled beat for stability.
    always @(negedge clk) begin
        beat_t cur;
        beat_t expB;
        if (rst) begin
            heldValid = 1'b0;
        end else if (bus.out_valid) begin
            cur.data = bus.out_data;
            cur.sof  = bus.out_sof;
            cur.eol  = bus.out_eol;
            cur.eof  = bus.out_eof;
            if (heldValid) checkOutput($sformatf("stall_hold%0d", xferCount), 32'(cur), 32'(held));
            if (bus.out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput($sformatf("unexpected_beat%0d", xferCount), 32'(cur), 32'hFFFF_FFFF);
                end else begin
                    expB = expQ.pop_front();
                    checkOutput($sformatf("beat%0d", xferCount), 32'(cur), 32'(expB));
                end
                xferCount++;
                lastXferTime = $time;
                heldValid = 1'b0;
            end else begin
                held = cur;
                heldValid = 1'b1;
            end
        end else begin
            heldValid = 1'b0;
        end
    end

    initial begin
        int cycles;
        int base;
        bit doneSeen;

        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        cfgCols = '0;
        cfgRows = '0;
        cfgMode = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_frame_cnt", 32'(frameCnt), 32'd0);
        checkOutput("reset_data", 32'(bus.out_data), 32'd0);
        checkOutput("reset_sof", 32'(bus.out_sof), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] ramp 4x2, ready held high");
        applyStimulus(4, 2, 0, 1000);
        checkOutput("ramp_busy", 32'(busy), 32'd1);
        waitDone("ramp", 1'b1, cycles);

        $display("[TB] mode3 3x2 on second frame");
        applyStimulus(3, 2, 3, 1000);
        waitDone("mode3", 1'b1, cycles);

        $display("[TB] ramp 4x2, ready toggling");
        toggleReady = 1'b1;
        applyStimulus(4, 2, 0, 1000);
        waitDone("toggle", 1'b1, cycles);

        $display("[TB] checkerboard 10x1 and constant 2x2");
        applyStimulus(10, 1, 2, 1000);
        waitDone("checker", 1'b1, cycles);
        applyStimulus(2, 2, 1, 1000);
        waitDone("const", 1'b1, cycles);

        $display("[TB] abort on stalled third beat");
        applyStimulus(4, 2, 0, 2);
        base = xferCount;
        for (int i = 0; i < DEF_DELAY + 50 && xferCount < base + 2; i++) begin
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        checkOutput("abort_stalled_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        checkOutput("abort_valid_dropped", 32'(bus.out_valid), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_frame_cnt", 32'(frameCnt), 32'(modelFrameCnt));
        doneSeen = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < DEF_DELAY + 10; i++) begin
            @(negedge clk);
            if (done || busy) doneSeen = 1'b1;
        end
        checkOutput("abort_no_done", 32'(doneSeen), 32'd0);
        checkOutput("abort_xfers", 32'(xferCount - base), 32'd2);
        @(posedge clk);
        #1;
        applyStimulus(4, 2, 0, 1000);
        waitDone("after_abort", 1'b1, cycles);

        $display("[TB] zero rows with start pulses during busy");
        pokeStart = 1'b1;
        applyStimulus(4, 0, 0, 1000);
        waitDone("zero_rows", HAS_HDR, cycles);
        checkOutput("zero_rows_latency", 32'(cycles + 1), 32'(DEF_DELAY + 1 + (HAS_HDR ? 3 : 0)));

        $display("[TB] single pixel frame");
        applyStimulus(1, 1, 0, 1000);
        waitDone("one_by_one", 1'b1, cycles);

        $display("[TB] async reset mid-frame");
        applyStimulus(8, 2, 0, 1000);
        base = xferCount;
        for (int i = 0; i < DEF_DELAY + 50 && xferCount < base + 3; i++) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_mid_data", 32'(bus.out_data), 32'd0);
        checkOutput("rst_mid_markers", 32'({bus.out_sof, bus.out_eol, bus.out_eof}), 32'd0);
        checkOutput("rst_mid_busy", 32'(busy), 32'd0);
        checkOutput("rst_mid_frame_cnt", 32'(frameCnt), 32'd0);
        expQ.delete();
        modelFrameCnt = 16'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1, 1, 3, 1000);
        waitDone("post_reset", 1'b1, cycles);

        checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/up_image_gen.md
Name: up_image_gen

Overview:
Parametrised test-image source for the USB upload path; successor to the fixed 4096-beat ramp uploader.
- Streams one frame per start request: rows x cols pixels with run-time size and selectable pattern.
- Uses a valid/ready handshake so the USB TX FIFO can apply backpressure.
- Adds frame markers, abort and a done pulse; sits between the control register block and the USB TX FIFO.

Parameters:
DATA_W, 16, pixel/beat width in bits (>=8)
DIM_W, 13, width of row/column counters and size inputs
DELAY_W, 20, width of pre-frame delay counter
DEF_DELAY, 400000, delay cycles between start and first beat

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle request; ignored while busy
abort  in  1  cancel current frame
cfg_cols  in  DIM_W  pixels per row, sampled at start
cfg_rows  in  DIM_W  rows per frame, sampled at start
cfg_mode  in  2  pattern select, sampled at start
out_data  out  DATA_W  pixel beat
out_valid  out  1  beat valid
out_ready  in  1  sink accepts beat
out_sof  out  1  qualifies first beat of frame
out_eol  out  1  qualifies last beat of each row
out_eof  out  1  qualifies last beat of frame
busy  out  1  high from accepted start until IDLE
done  out  1  one-cycle pulse, frame completed
frame_cnt  out  16  completed-frame count

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0, including frame_cnt. Counters cleared.
- Beat transfer occurs on any cycle with out_valid & out_ready.
- While out_valid=1 and out_ready=0: out_data, sof, eol and eof are held stable and valid stays high.
- States:
  - IDLE: start=1 -> latch cfg_cols, cfg_rows and cfg_mode; busy=1; next DELAY.
  - DELAY: counts DEF_DELAY cycles, then goes to STREAM, or to HEADER when the option is enabled. out_valid=0.
  - STREAM: issues beats for row 0..rows-1, col 0..cols-1, column fastest. The first beat is valid on the cycle after DELAY exits.
  - DONE: one cycle. done=1, frame_cnt+1 (wraps at 16 bits). Next IDLE, busy=0.
- Transfer of the eof beat -> DONE on the next cycle, with out_valid=0 in that cycle.
- Patterns (col and row are zero-extended or truncated to DATA_W):
  - 0: ramp, data = col.
  - 1: constant, all ones.
  - 2: checkerboard, all bits = col[3]^row[3].
  - 3: data = (col + row + frame_cnt) mod 2^DATA_W.
- Markers:
  - sof=1 only on the (0,0) beat.
  - eol=1 on col==cols-1.
  - eof=1 on the beat with row==rows-1 and col==cols-1.
- Zero size: cfg_cols==0 or cfg_rows==0 -> DELAY is still executed, then DONE directly. No beats, done pulses, frame_cnt increments.
- Size 1x1: a single beat with sof, eol and eof all 1.
- abort in any non-IDLE state -> IDLE on the next edge.
  - out_valid drops immediately on that edge, even mid-stall. Counters clear.
  - No done pulse, frame_cnt unchanged.
  - abort takes priority over start and over a simultaneous transfer.
- start during busy: ignored, no queueing. start in the same cycle as DONE: ignored.
- Max frame: 2^DIM_W-1 per dimension; counters never overflow.

Optional Feature:
Macro FRAME_HEADER_EN.
- Defined: HEADER state runs between DELAY and STREAM and emits 3 beats under the same handshake.
  - Beat 1: all ones (sync).
  - Beat 2: {mode, cols} zero-extended.
  - Beat 3: frame_cnt truncated or zero-extended to DATA_W.
  - sof moves to header beat 1. eol/eof are never set on header beats.
  - Zero-size frames still emit the header.
- Undefined: HEADER state and its logic are absent; behaviour is as above.

Test Plan:
- cols=4, rows=2, mode0, ready=1 -> 8 beats, data 0,1,2,3,0,1,2,3. eol on beats 4 and 8, sof on beat 1, eof on beat 8. done 1 cycle after beat 8; frame_cnt=1.
- Same frame with ready toggling 1/0 each cycle -> identical beat sequence, each stalled beat held stable. Total 8 transfers.
- mode3, cols=3, rows=2, second frame (frame_cnt=1) -> data 1,2,3,2,3,4.
- abort asserted on the 3rd beat while ready=0 -> valid=0 on the next cycle, busy=0, no done, frame_cnt unchanged. A new start then produces a clean frame beginning with sof.
- cfg_rows=0 -> no valid beats, done pulses after DEF_DELAY+1 cycles. start pulses during busy have no effect.
- rst asserted mid-STREAM -> all outputs 0 asynchronously, before the next clk edge. With FRAME_HEADER_EN: 1x1 frame gives FFFF, {mode,cols}, frame_cnt, then the pixel beat with eol=eof=1.
